// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// With SERIAL_ADDER_SUB_EN defined, the bundle carries a subtract select.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, sub, input  busy, done, sum, carry_out);
  modport slave  (input  start, a, b, sub, output busy, done, sum, carry_out);
`else
  modport master (output start, a, b, input  busy, done, sum, carry_out);
  modport slave  (input  start, a, b, output busy, done, sum, carry_out);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell plus carry flop.
// Optional subtract mode (a-b) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ha (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic s1, c1, c2;

  serial_adder_ha u_ha0 (.x_i(a_i), .y_i(b_i), .s_o(s1),  .c_o(c1));
  serial_adder_ha u_ha1 (.x_i(s1),  .y_i(c_i), .s_o(s_o), .c_o(c2));

  assign c_o = c1 | c2;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic             fa_s, fa_c;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] b_cap;
  logic             c_init;

  serial_adder_fa u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (c_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign res_next = WIDTH'({fa_s, res_sh_q} >> 1);

  // Subtract is a + ~b + 1: invert b once at capture and seed the carry.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_cap  = bus.sub ? ~bus.b : bus.b;
  assign c_init = bus.sub;
`else
  assign b_cap  = bus.b;
  assign c_init = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_RUN;
          a_sh_d   = bus.a;
          b_sh_d   = b_cap;
          res_sh_d = '0;
          c_d      = c_init;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next;
        c_d      = fa_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = res_next;
          cout_d  = fa_c;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 instance plus a WIDTH=1 instance.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] prev_s;
  logic       prev_c;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts one WIDTH=8 op and runs it to the done cycle; optionally pokes a
  // second start (0x01+0x01) mid-run, which must be ignored.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] es, input logic ec,
                      input string tag, input bit inject);
    bus8.a = av; bus8.b = bv; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    chk({tag, " busy@k"}, 64'(bus8.busy), 64'd1);
    chk({tag, " done@k"}, 64'(bus8.done), 64'd0);
    for (int i = 1; i < 8; i++) begin
      if (inject && i == 3) begin
        bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01;
      end
      step();
      bus8.start = 1'b0;
      chk({tag, " busy run"}, 64'(bus8.busy), 64'd1);
      chk({tag, " done run"}, 64'(bus8.done), 64'd0);
      chk({tag, " sum hold"}, 64'(bus8.sum), 64'(prev_s));
      chk({tag, " cout hold"}, 64'(bus8.carry_out), 64'(prev_c));
    end
    step();
    chk({tag, " busy end"}, 64'(bus8.busy), 64'd0);
    chk({tag, " done end"}, 64'(bus8.done), 64'd1);
    chk({tag, " sum"}, 64'(bus8.sum), 64'(es));
    chk({tag, " cout"}, 64'(bus8.carry_out), 64'(ec));
    prev_s = es;
    prev_c = ec;
  endtask

  initial begin
    logic [1:0] exp1 [4];
    exp1[0] = 2'b00; exp1[1] = 2'b01; exp1[2] = 2'b01; exp1[3] = 2'b10;
    prev_s = 8'h00;
    prev_c = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus8.sub = 1'b0;
    bus1.sub = 1'b0;
`endif
    rst = 1'b1;
    bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h33;
    bus1.start = 1'b1; bus1.a = 1'b1;  bus1.b = 1'b1;

    // reset held two cycles with start asserted
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst busy", 64'(bus8.busy), 64'd0);
      chk("rst done", 64'(bus8.done), 64'd0);
      chk("rst sum", 64'(bus8.sum), 64'h00);
      chk("rst cout", 64'(bus8.carry_out), 64'd0);
      chk("rst busy1", 64'(bus1.busy), 64'd0);
    end
    rst = 1'b0;
    bus8.start = 1'b0;
    bus1.start = 1'b0;
    step();
    chk("post-rst busy", 64'(bus8.busy), 64'd0);
    chk("post-rst sum", 64'(bus8.sum), 64'h00);

    run8(8'h5A, 8'h33, 8'h8D, 1'b0, "5A+33", 1'b0);
    step();
    chk("done pulse", 64'(bus8.done), 64'd0);

    run8(8'hFF, 8'h01, 8'h00, 1'b1, "FF+01", 1'b0);
    step();
    run8(8'hFF, 8'hFF, 8'hFE, 1'b1, "FF+FF", 1'b0);
    step();

    // ignored mid-run start, then back-to-back start in the done cycle
    run8(8'h10, 8'h20, 8'h30, 1'b0, "10+20 inj", 1'b1);
    run8(8'h01, 8'h01, 8'h02, 1'b0, "b2b 01+01", 1'b0);
    step();
    chk("b2b done clr", 64'(bus8.done), 64'd0);

    // reset on the 4th processing edge aborts the op
    bus8.a = 8'h5A; bus8.b = 8'h33; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort busy", 64'(bus8.busy), 64'd0);
    chk("abort done", 64'(bus8.done), 64'd0);
    chk("abort sum", 64'(bus8.sum), 64'h00);
    chk("abort cout", 64'(bus8.carry_out), 64'd0);
    prev_s = 8'h00;
    prev_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("abort no done", 64'(bus8.done), 64'd0);
    end
    run8(8'h0F, 8'h01, 8'h10, 1'b0, "0F+01", 1'b0);
    step();

`ifdef SERIAL_ADDER_SUB_EN
    bus8.sub = 1'b1;
    run8(8'h10, 8'h01, 8'h0F, 1'b1, "10-01", 1'b0);
    step();
    run8(8'h01, 8'h02, 8'hFF, 1'b0, "01-02", 1'b0);
    step();
    bus8.sub = 1'b0;
`endif

    // WIDTH=1 exhaustive
    for (int i = 0; i < 4; i++) begin
      bus1.a = 1'((i >> 1) & 1); bus1.b = 1'(i & 1); bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      chk("w1 busy", 64'(bus1.busy), 64'd1);
      chk("w1 done@k", 64'(bus1.done), 64'd0);
      step();
      chk("w1 done", 64'(bus1.done), 64'd1);
      chk("w1 busy end", 64'(bus1.busy), 64'd0);
      chk("w1 result", 64'({bus1.carry_out, bus1.sum}), 64'(exp1[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder: adds two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell (two half-adder stages plus a carry register).
- Sequential successor to the combinational half-adder blocks. Trades latency for area.
- Start/busy/done handshake so a controller or testbench can issue back-to-back operations.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset, sampled on rising edge of clk.
- start  input  1  request; sampled only while busy=0.
- a  input  WIDTH  operand A; captured on the edge that accepts start.
- b  input  WIDTH  operand B; captured on the edge that accepts start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  registered result; holds until the next completion.
- carry_out  output  1  registered carry out of the MSB; holds with sum.

Behaviour:
- Reset (rst=1 at an edge):
  - state<=IDLE; busy, done, sum, carry_out <=0.
  - Internal shift registers, carry register and bit counter are cleared.
  - rst has priority over start and over any in-flight operation.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE -> RUN: edge k with start=1.
  - Latch a, b into operand shift registers.
  - carry register <=0; counter <=0.
  - busy<=1 and done<=0 on the same edge.
- RUN, edges k+1 .. k+WIDTH, one bit per edge:
  - s = a0 ^ b0 ^ c.
  - c <= (a0&b0) | (c&(a0^b0)).
  - s shifts into the result register from the MSB side; operand registers shift right by 1.
  - Counter increments.
- Completion, edge k+WIDTH (counter reaches WIDTH-1 before this edge):
  - sum <= full result; carry_out <= final carry.
  - done<=1; busy<=0; state<=IDLE.
- Latency:
  - done is high in the cycle after edge k+WIDTH.
  - busy is high for exactly WIDTH cycles.
  - WIDTH=1: done follows the start edge by one edge.
- done is a single-cycle pulse and clears on the next edge unless another completion occurs.
- sum and carry_out change only on completion edges; intermediate shift values are never visible on the outputs.
- start while busy=1 is ignored; operands are not resampled.
- start in the done cycle (busy=0) is accepted, giving back-to-back operation with no idle gap.
- rst mid-RUN: the operation is aborted, no done is issued, and outputs are zero on the next cycle.
- Arithmetic is modulo 2^WIDTH with the carry reported separately; {carry_out,sum} = a+b exactly.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Extra input port sub (1 bit), captured with start.
  - sub=1 computes a-b: b is inverted at capture, carry register is initialised to 1.
  - carry_out=1 means no borrow (a>=b, unsigned).
  - sub=0 behaves identically to the add-only build.
- When undefined: the sub port is absent; add only.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 -> busy=0, done=0, sum=0x00, carry_out=0 throughout and after release.
- WIDTH=8, a=0x5A, b=0x33, start pulse:
  - busy high exactly 8 cycles.
  - done pulses once, on the cycle after the 8th processing edge.
  - sum=0x8D, carry_out=0.
- Carry cases:
  - a=0xFF, b=0x01 -> sum=0x00, carry_out=1.
  - a=0xFF, b=0xFF -> sum=0xFE, carry_out=1.
  - Previous result holds on the outputs during each run.
- Handshake:
  - Second start with a=0x01, b=0x01 at bit 3 of an op on 0x10+0x20 -> ignored; result 0x30.
  - Start 0x01+0x01 in the done cycle -> accepted; done 8 cycles later with sum=0x02.
- Reset mid-op: assert rst at the 4th processing edge of 0x5A+0x33 -> next cycle busy=0, sum=0x00, no done. A subsequent start of 0x0F+0x01 gives sum=0x10.
- WIDTH=1 exhaustive (a,b in 00,01,10,11) -> {carry_out,sum}=00,01,01,10 with done one edge after start.
- With SERIAL_ADDER_SUB_EN, WIDTH=8:
  - 0x10-0x01 -> sum=0x0F, carry_out=1.
  - 0x01-0x02 -> sum=0xFF, carry_out=0.
